// File: rtl/hazard_ctrl.sv
// Decode-side interlock: RAW stall/bubble, branch squash, mem-wait freeze, halt drain.
// Outputs are combinational from registered state + current inputs; state updates on the rising edge.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs_sel,
  input  logic             id_rs_used,
  input  logic [2:0]       id_rt_sel,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [2:0]       id_wr_sel,
  input  logic             id_halt,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             stall_fd,
  output logic             bubble_de,
  output logic             flush_fd,
  output logic             freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic       v;
    logic [2:0] sel;
    logic       halt;
  } sb_t;

  // WB is the last stage, so its halt flag is never consulted.
  typedef struct packed {
    logic       v;
    logic [2:0] sel;
  } wb_t;

  state_t           state_q, state_d;
  sb_t              ex_q, ex_d, mem_q, mem_d;
  wb_t              wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_hit, rt_hit, hazard;
  logic is_drain, is_halted, frozen;
  logic can_issue, issue_wr, issue_halt;

  always_comb begin
    rs_hit = (ex_q.v  && (ex_q.sel  == id_rs_sel)) ||
             (mem_q.v && (mem_q.sel == id_rs_sel)) ||
             (wb_q.v  && (wb_q.sel  == id_rs_sel));
    rt_hit = (ex_q.v  && (ex_q.sel  == id_rt_sel)) ||
             (mem_q.v && (mem_q.sel == id_rt_sel)) ||
             (wb_q.v  && (wb_q.sel  == id_rt_sel));
    hazard = id_valid && ((id_rs_used && rs_hit) || (id_rt_used && rt_hit));

    is_drain  = (state_q == DRAIN);
    is_halted = (state_q == HALTED);
    frozen    = mem_busy || is_halted;

    // Once a halt is in flight nothing younger may enter the scoreboard.
    can_issue  = !is_drain && !hazard && !ex_br_taken;
    issue_wr   = id_valid && id_wr_en && can_issue;
    issue_halt = id_valid && id_halt && can_issue;
  end

  always_comb begin
    stall_fd  = 1'b0;
    bubble_de = 1'b0;
    flush_fd  = 1'b0;
    freeze    = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      if (frozen) begin
        freeze   = 1'b1;
        stall_fd = is_halted;
        halted   = is_halted;
      end else if (is_drain) begin
        stall_fd  = 1'b1;
        bubble_de = 1'b1;
        flush_fd  = ex_br_taken;
      end else begin
        stall_fd  = hazard && !ex_br_taken;
        bubble_de = hazard || ex_br_taken;
        flush_fd  = ex_br_taken;
      end
    end
  end

  always_comb begin
    if (frozen) begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
    end else begin
      ex_d  = '{v: issue_wr, sel: id_wr_sel, halt: issue_halt};
      mem_d = ex_q;
      wb_d  = '{v: mem_q.v, sel: mem_q.sel};
    end

    cnt_d = cnt_q;
    if ((stall_fd || freeze) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
        end else if (issue_halt) begin
          state_d = DRAIN;
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_d = issue_halt ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        // Halt is about to move into WB: core is stopped from the next cycle.
        if (!mem_busy && mem_q.halt) begin
          state_d = HALTED;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected outputs queued per driven cycle, popped at the falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_halt;
  logic [2:0]  id_rs_sel, id_rt_sel, id_wr_sel;
  logic        ex_br_taken, mem_busy;

  logic        stall_fd, bubble_de, flush_fd, freeze, halted;
  logic [15:0] stall_cnt;
  logic        stall_fd4, bubble_de4, flush_fd4, freeze4, halted4;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_sel(id_rs_sel), .id_rs_used(id_rs_used),
    .id_rt_sel(id_rt_sel), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_sel(id_wr_sel), .id_halt(id_halt),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .stall_fd(stall_fd), .bubble_de(bubble_de), .flush_fd(flush_fd),
    .freeze(freeze), .halted(halted), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_sel(id_rs_sel), .id_rs_used(id_rs_used),
    .id_rt_sel(id_rt_sel), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_sel(id_wr_sel), .id_halt(id_halt),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .stall_fd(stall_fd4), .bubble_de(bubble_de4), .flush_fd(flush_fd4),
    .freeze(freeze4), .halted(halted4), .stall_cnt(stall_cnt4)
  );

  typedef struct packed {
    logic       rst;
    logic       vld;
    logic       rsu;
    logic [2:0] rs;
    logic       rtu;
    logic [2:0] rt;
    logic       we;
    logic [2:0] wd;
    logic       hlt;
    logic       br;
    logic       busy;
  } in_t;

  // outs = {stall_fd, bubble_de, flush_fd, freeze, halted}
  typedef struct packed {
    logic [4:0]  outs;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt_m;
  logic [3:0]  cnt4_m;
  in_t         n, t, r;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic in_t ins(input int we, input int wd, input int ru, input int rs,
                              input int tu, input int rt);
    in_t x;
    x     = '0;
    x.vld = 1'b1;
    x.we  = 1'(we);
    x.wd  = 3'(wd);
    x.rsu = 1'(ru);
    x.rs  = 3'(rs);
    x.rtu = 1'(tu);
    x.rt  = 3'(rt);
    return x;
  endfunction

  task automatic cyc(input string tag, input in_t i, input logic [4:0] e);
    exp_t x;
    rst         = i.rst;
    id_valid    = i.vld;
    id_rs_used  = i.rsu;
    id_rs_sel   = i.rs;
    id_rt_used  = i.rtu;
    id_rt_sel   = i.rt;
    id_wr_en    = i.we;
    id_wr_sel   = i.wd;
    id_halt     = i.hlt;
    ex_br_taken = i.br;
    mem_busy    = i.busy;
    x.outs = e;
    x.cnt  = cnt_m;
    x.cnt4 = cnt4_m;
    exp_q.push_back(x);
    @(negedge clk);
    x = exp_q.pop_front();
    check_val({tag, "/outs"},  32'({stall_fd, bubble_de, flush_fd, freeze, halted}), 32'(x.outs));
    check_val({tag, "/outs4"}, 32'({stall_fd4, bubble_de4, flush_fd4, freeze4, halted4}), 32'(x.outs));
    check_val({tag, "/cnt"},   32'(stall_cnt), 32'(x.cnt));
    check_val({tag, "/cnt4"},  32'(stall_cnt4), 32'(x.cnt4));
    if (i.rst) begin
      cnt_m  = '0;
      cnt4_m = '0;
    end else if (e[4] || e[1]) begin
      if (cnt_m != 16'hffff) cnt_m = cnt_m + 16'd1;
      if (cnt4_m != 4'hf)    cnt4_m = cnt4_m + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n = '0;
    r = '0;
    r.rst = 1'b1;
    rst = 1'b1;
    id_valid = 1'b0; id_rs_used = 1'b0; id_rt_used = 1'b0; id_wr_en = 1'b0; id_halt = 1'b0;
    id_rs_sel = '0; id_rt_sel = '0; id_wr_sel = '0; ex_br_taken = 1'b0; mem_busy = 1'b0;
    cnt_m = '0;
    cnt4_m = '0;
    repeat (2) @(posedge clk);
    #1;

    // Outputs stay quiet under reset even with a would-be hazard presented.
    t = ins(1, 1, 1, 1, 0, 0);
    t.rst = 1'b1;
    cyc("rst_quiet", t, 5'b00000);

    // Back-to-back dependency: three stall cycles, issue on the fourth.
    cyc("b2b_prod", ins(1, 1, 0, 0, 0, 0), 5'b00000);
    for (int k = 0; k < 3; k++) cyc("b2b_stall", ins(1, 4, 1, 1, 0, 0), 5'b11000);
    cyc("b2b_issue", ins(1, 4, 1, 1, 0, 0), 5'b00000);
    for (int k = 0; k < 3; k++) cyc("nop", n, 5'b00000);

    // Distance 3 on rt: one stall; unused sources never stall.
    cyc("d3_prod", ins(1, 3, 0, 0, 0, 0), 5'b00000);
    cyc("d3_ind1", ins(1, 5, 0, 0, 0, 0), 5'b00000);
    cyc("d3_ind2", ins(1, 6, 0, 0, 0, 0), 5'b00000);
    cyc("d3_stall", ins(0, 0, 0, 0, 1, 3), 5'b11000);
    cyc("d3_issue", ins(0, 0, 0, 0, 1, 3), 5'b00000);
    cyc("rt_unused", ins(0, 0, 0, 6, 0, 6), 5'b00000);

    // r0 is an ordinary register; distance 2 costs two stalls.
    cyc("r0_prod", ins(1, 0, 0, 0, 0, 0), 5'b00000);
    cyc("r0_ind", ins(0, 0, 0, 0, 0, 0), 5'b00000);
    for (int k = 0; k < 2; k++) cyc("r0_stall", ins(0, 0, 1, 0, 0, 0), 5'b11000);
    cyc("r0_issue", ins(0, 0, 1, 0, 0, 0), 5'b00000);
    for (int k = 0; k < 3; k++) cyc("nop", n, 5'b00000);

    // Branch beats hazard: squash, no scoreboard entry for the wrong-path write.
    cyc("br_prod", ins(1, 2, 0, 0, 0, 0), 5'b00000);
    t = ins(1, 7, 1, 2, 0, 0);
    t.br = 1'b1;
    cyc("br_squash", t, 5'b01100);
    cyc("br_noentry", ins(0, 0, 1, 7, 0, 0), 5'b00000);
    cyc("br_r2_wb", ins(0, 0, 1, 2, 0, 0), 5'b11000);
    cyc("br_r2_go", ins(0, 0, 1, 2, 0, 0), 5'b00000);
    for (int k = 0; k < 3; k++) cyc("nop", n, 5'b00000);

    // mem_busy for 4 cycles in the middle of a 3-cycle stall: total 7.
    cyc("mb_rst", r, 5'b00000);
    cyc("mb_prod", ins(1, 1, 0, 0, 0, 0), 5'b00000);
    cyc("mb_stall", ins(0, 0, 1, 1, 0, 0), 5'b11000);
    t = ins(0, 0, 1, 1, 0, 0);
    t.busy = 1'b1;
    for (int k = 0; k < 3; k++) cyc("mb_freeze", t, 5'b00010);
    t.br = 1'b1;
    cyc("mb_br_frz", t, 5'b00010);
    for (int k = 0; k < 2; k++) cyc("mb_stall", ins(0, 0, 1, 1, 0, 0), 5'b11000);
    cyc("mb_issue", ins(0, 0, 1, 1, 0, 0), 5'b00000);
    check_val("mb_total", 32'(stall_cnt), 32'd7);
    for (int k = 0; k < 3; k++) cyc("nop", n, 5'b00000);

    // Halt drain with a write ahead, then stay halted long enough to saturate the 4-bit counter.
    cyc("h_prod", ins(1, 2, 0, 0, 0, 0), 5'b00000);
    t = n;
    t.vld = 1'b1;
    t.hlt = 1'b1;
    cyc("h_issue", t, 5'b00000);
    t = n;
    t.br = 1'b1;
    cyc("h_drain_br", t, 5'b11100);
    t = n;
    t.busy = 1'b1;
    cyc("h_drain_frz", t, 5'b00010);
    cyc("h_drain", ins(1, 3, 0, 0, 0, 0), 5'b11000);
    for (int k = 0; k < 20; k++) cyc("h_halted", n, 5'b10011);
    check_val("sat4", 32'(stall_cnt4), 32'd15);

    // Reset leaves HALTED with no residual stall; hazards work again afterwards.
    cyc("h_rst", r, 5'b00000);
    cyc("h_after", n, 5'b00000);
    cyc("re_prod", ins(1, 5, 0, 0, 0, 0), 5'b00000);
    cyc("re_stall", ins(0, 0, 0, 0, 1, 5), 5'b11000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
